bcd_mod_counter: RTL and testbench
==================================

Name: bcd_mod_counter

Overview:
- Parametrised multi-digit BCD counter with programmable modulus range [MIN_VALUE, MAX_VALUE].
- Supports up/down counting, parallel load with validation, synchronous clear, and terminal-count output for cascading.
- Replaces the fixed single-digit 0-9 counter in the alarm-clock time path. One instance per field: seconds/minutes 00-59, hours 00-23 or 01-12, and alarm-set registers.

Parameters:
- DIGITS, 2: number of BCD digits; legal range 1-4.
- MAX_VALUE, 59: highest count, decimal integer; must be < 10^DIGITS.
- MIN_VALUE, 0: lowest count and reset value; must be < MAX_VALUE.

Ports:
- Clk  input  1  clock, rising edge.
- Clr  input  1  reset, asynchronous, active-low; forces COUNT to BCD(MIN_VALUE).
- Enable  input  1  global clock-enable; when 0 the state holds and TC=0.
- Sclr  input  1  synchronous clear to BCD(MIN_VALUE), active-high.
- LD  input  1  parallel load request, active-high.
- D_IN  input  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
- Cnt  input  1  count request; cascade input, tie to previous stage's TC.
- Dir  input  1  1 = count up, 0 = count down.
- COUNT  output  4*DIGITS  registered BCD count.
- TC  output  1  combinational terminal count, for cascade.
- LD_ERR  output  1  registered one-cycle pulse on a rejected load.

Behaviour:
- Reset (Clr=0, asynchronous): COUNT=BCD(MIN_VALUE), LD_ERR=0. Reset is effective immediately, including mid-load or mid-count. The first action after release takes effect on the first rising Clk edge.
- Priority on a rising Clk edge when Enable=1: Sclr > LD > Cnt.
- Enable=0: COUNT holds, LD_ERR <= 0, all requests are ignored.
- Sclr: COUNT <= BCD(MIN_VALUE); LD_ERR <= 0.
- LD, valid: COUNT <= D_IN with one-cycle latency; LD_ERR <= 0.
  - Valid means every nibble ≤ 9 and the decoded value is within [MIN_VALUE, MAX_VALUE].
- LD, invalid: COUNT unchanged; LD_ERR <= 1 for exactly one cycle.
- Cnt with Dir=1:
  - COUNT == MAX_VALUE -> MIN_VALUE (wrap).
  - Otherwise BCD +1: digit 9 -> 0 with carry into the next digit.
- Cnt with Dir=0:
  - COUNT == MIN_VALUE -> MAX_VALUE (wrap).
  - Otherwise BCD -1: digit 0 -> 9 with borrow from the next digit.
- TC = Enable & Cnt & ~Sclr & ~LD & ((Dir & COUNT==MAX) | (~Dir & COUNT==MIN)).
  - TC is asserted in the same cycle as the wrapping edge, so the next stage advances on that edge.
  - TC is purely combinational from registered COUNT and inputs; there is no feedback path from TC into this stage.
- Any Dir change takes effect on the next counted edge; there is no hysteresis.
- LD_ERR is cleared on every enabled edge that is not an invalid load.
- Arithmetic is per-digit 4-bit BCD with ripple carry/borrow between digits; no binary intermediate of the full value.
- Range comparisons use elaboration-time BCD constants MAX_BCD and MIN_BCD.
- COUNT never holds a value outside [MIN_VALUE, MAX_VALUE] or a non-BCD nibble. An assertion checks this.

Decomposition:
- Shared package/include clock_pkg holds:
  - function to_bcd(int) -> BCD vector (elaboration use only);
  - constants SEC_MAX=59, MIN_MAX=59, HR24_MAX=23, HR12_MIN=1, HR12_MAX=12;
  - width macro BCD_W(d)=4*d.
- One sub-module, bcd_digit: a single-digit 0-9 incrementer/decrementer.
  - Inputs: digit, dir, cin.
  - Outputs: next digit, cout (carry/borrow).
  - It is combinational and is instantiated DIGITS times in a generate chain.
- The top level owns the registers, wrap override, load validation, priority and TC.

Test Plan:
- Defaults (2 digits, 0-59): release Clr, Enable=1, Cnt=1, Dir=1 for 60 edges.
  - Required: COUNT runs 00..59, then 00.
  - Required: TC=1 only during the cycle COUNT=0x59.
  - Required: 0x09 -> 0x10 transition checked.
- Down count: from COUNT=0x00, Dir=0, Cnt=1, one edge -> COUNT=0x59 with TC=1 in that cycle. Next edge -> 0x58.
- Load validation:
  - LD=1, D_IN=0x45 -> COUNT=0x45 next edge, LD_ERR=0.
  - D_IN=0x60 -> COUNT stays 0x45, LD_ERR=1 for one cycle.
  - D_IN=0x3A -> rejected, LD_ERR=1.
- Priority and enable:
  - Sclr=1, LD=1, Cnt=1 together -> COUNT=0x00.
  - LD=1, Cnt=1 -> loaded value, no increment.
  - Enable=0 with LD=1 -> COUNT unchanged, LD_ERR=0, TC=0.
- Hours, 12-hour mode (MIN_VALUE=1, MAX_VALUE=12):
  - Reset -> COUNT=0x01.
  - Up count from 0x12 -> 0x01.
  - Down from 0x01 -> 0x12.
  - LD of 0x00 -> rejected, LD_ERR=1.
- Async reset mid-operation: at COUNT=0x37, assert Clr between clock edges -> COUNT=BCD(MIN) immediately, LD_ERR=0.
  - Required: with Cnt held, the count resumes 0x00, 0x01 from the first edge after Clr release.
- Cascade: two instances (seconds into minutes via TC -> Cnt) from 0x59/0x59, one edge -> both 0x00; minutes TC=1 in the preceding cycle.

Source files
------------

// File: rtl/bcd_mod_counter_pkg.sv
// bcd_mod_counter_pkg: shared BCD helpers and time-field limits for the alarm-clock counters
//   BCD_W(d)  width in bits of a d-digit BCD vector
//   to_bcd    integer to 4-digit BCD, for elaboration-time constants only
`define BCD_W(d) (4*(d))
package bcd_mod_counter_pkg;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MIN = 1;
  localparam int HR12_MAX = 12;
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
endpackage

// File: rtl/bcd_mod_counter_if.sv
// bcd_mod_counter_if: request/result bundle of one BCD counter stage
//   master: drives Enable, Sclr, LD, D_IN, Cnt, Dir; reads COUNT, TC, LD_ERR
//   slave:  the counter itself
interface bcd_mod_counter_if #(parameter int DIGITS = 2);
  logic Enable, Sclr, LD, Cnt, Dir, TC, LD_ERR;
  logic [`BCD_W(DIGITS)-1:0] D_IN, COUNT;
  modport master(output Enable, Sclr, LD, D_IN, Cnt, Dir, input COUNT, TC, LD_ERR);
  modport slave(input Enable, Sclr, LD, D_IN, Cnt, Dir, output COUNT, TC, LD_ERR);
endinterface

// File: rtl/bcd_mod_counter_digit.sv
// bcd_digit: one BCD digit stepped up or down when cin is set
//   digit/dir/cin in; next digit and carry/borrow cout out
module bcd_digit (
  input  logic [3:0] digit,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] next,
  output logic       cout
);
  logic edge_val;
  always_comb begin
    edge_val = dir ? digit == 4'd9 : digit == 4'd0;
    cout = cin & edge_val;
    next = !cin ? digit : edge_val ? (dir ? 4'd0 : 4'd9) : dir ? digit + 4'd1 : digit - 4'd1;
  end
endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: multi-digit BCD counter over [MIN_VALUE, MAX_VALUE] with load, clear and cascade TC
//   Clk  rising-edge clock
//   Clr  asynchronous active-low reset to MIN_VALUE
//   bus  slave side of bcd_mod_counter_if (requests in; COUNT, TC, LD_ERR out)
module bcd_mod_counter
  import bcd_mod_counter_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int MAX_VALUE = SEC_MAX,
  parameter int MIN_VALUE = 0
) (
  input logic Clk,
  input logic Clr,
  bcd_mod_counter_if.slave bus
);
  localparam int W = `BCD_W(DIGITS);
  localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MAX_VALUE));
  localparam logic [W-1:0] MIN_BCD = W'(to_bcd(MIN_VALUE));
  function automatic logic is_bcd(input logic [W-1:0] v);
    is_bcd = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (v[4*i+:4] > 4'd9) is_bcd = 1'b0;
  endfunction
  logic [W-1:0] count, step;
  logic [DIGITS:0] c;
  logic at_end, ld_ok, ld_err;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .digit(count[4*i+:4]),
      .dir  (bus.Dir),
      .cin  (c[i]),
      .next (step[4*i+:4]),
      .cout (c[i+1])
    );
  end
  // BCD vectors with legal nibbles order the same as their decimal values
  always_comb begin
    at_end = bus.Dir ? count == MAX_BCD : count == MIN_BCD;
    ld_ok = is_bcd(bus.D_IN) && bus.D_IN >= MIN_BCD && bus.D_IN <= MAX_BCD;
  end
  always_ff @(posedge Clk or negedge Clr)
    if (!Clr) begin
      count  <= MIN_BCD;
      ld_err <= 1'b0;
    end else if (bus.Enable) begin
      ld_err <= ~bus.Sclr & bus.LD & ~ld_ok;
      count  <= bus.Sclr ? MIN_BCD :
                bus.LD   ? (ld_ok ? bus.D_IN : count) :
                bus.Cnt  ? (at_end ? (bus.Dir ? MIN_BCD : MAX_BCD) : step) : count;
    end else begin
      ld_err <= 1'b0;
    end
  assign bus.COUNT  = count;
  assign bus.LD_ERR = ld_err;
  assign bus.TC     = bus.Enable & bus.Cnt & ~bus.Sclr & ~bus.LD & at_end;
  ap_range: assert property (@(posedge Clk) disable iff (!Clr)
    is_bcd(count) && count >= MIN_BCD && count <= MAX_BCD);
  // a ripple out of the top digit only happens where the wrap override replaces it
  ap_ripple: assert property (@(posedge Clk) disable iff (!Clr) !c[DIGITS] || at_end);
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: directed and randomized checks of bcd_mod_counter against an integer model
module tb_bcd_mod_counter;
  import bcd_mod_counter_pkg::*;
  logic Clk = 1'b0;
  logic Clr = 1'b1;
  int total = 0, passed = 0, fails = 0;
  int sv, hv;
  bit se, he;
  bcd_mod_counter_if #(.DIGITS(2)) s_if ();
  bcd_mod_counter_if #(.DIGITS(2)) m_if ();
  bcd_mod_counter_if #(.DIGITS(2)) h_if ();
  assign m_if.Cnt = s_if.TC;
  bcd_mod_counter #(.DIGITS(2), .MAX_VALUE(SEC_MAX), .MIN_VALUE(0)) u_sec (.Clk(Clk), .Clr(Clr), .bus(s_if));
  bcd_mod_counter #(.DIGITS(2), .MAX_VALUE(MIN_MAX), .MIN_VALUE(0)) u_min (.Clk(Clk), .Clr(Clr), .bus(m_if));
  bcd_mod_counter #(.DIGITS(2), .MAX_VALUE(HR12_MAX), .MIN_VALUE(HR12_MIN)) u_hr (.Clk(Clk), .Clr(Clr), .bus(h_if));
  always #5 Clk = ~Clk;
  function automatic int bcd(input int v);
    return (v / 10 % 10) * 16 + v % 10;
  endfunction
  function automatic int dec(input logic [7:0] d);
    int hi, lo;
    hi = int'(d[7:4]);
    lo = int'(d[3:0]);
    return (hi > 9 || lo > 9) ? -1 : hi * 10 + lo;
  endfunction
  function automatic int nxt(input int v, mn, mx, input bit en, sc, ld, input logic [7:0] d, input bit cn, dr);
    int x;
    x = dec(d);
    if (!en) return v;
    if (sc) return mn;
    if (ld) return (x >= mn && x <= mx) ? x : v;
    if (cn) return dr ? (v == mx ? mn : v + 1) : (v == mn ? mx : v - 1);
    return v;
  endfunction
  function automatic bit nerr(input int mn, mx, input bit en, sc, ld, input logic [7:0] d);
    int x;
    x = dec(d);
    return en && !sc && ld && !(x >= mn && x <= mx);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic set_s(input bit en, sc, ld, input logic [7:0] d, input bit cn, dr);
    s_if.Enable = en; s_if.Sclr = sc; s_if.LD = ld; s_if.D_IN = d; s_if.Cnt = cn; s_if.Dir = dr;
  endtask
  task automatic set_h(input bit en, sc, ld, input logic [7:0] d, input bit cn, dr);
    h_if.Enable = en; h_if.Sclr = sc; h_if.LD = ld; h_if.D_IN = d; h_if.Cnt = cn; h_if.Dir = dr;
  endtask
  initial begin
    set_s(0, 0, 0, 8'h00, 0, 1);
    set_h(0, 0, 0, 8'h00, 0, 1);
    m_if.Enable = 0; m_if.Sclr = 0; m_if.LD = 0; m_if.D_IN = 8'h00; m_if.Dir = 1;
    #2 Clr = 1'b0;
    #1;
    chk("reset_sec_count", 32'(s_if.COUNT), 32'h00);
    chk("reset_sec_ld_err", 32'(s_if.LD_ERR), 32'h0);
    chk("reset_hr_count", 32'(h_if.COUNT), 32'h01);
    set_s(1, 0, 0, 8'h00, 1, 1);
    @(negedge Clk) Clr = 1'b1;
    sv = 0;
    for (int i = 0; i < 60; i++) begin
      chk("up_tc", 32'(s_if.TC), 32'(sv == 59));
      tick;
      sv = (sv == 59) ? 0 : sv + 1;
      chk("up_count", 32'(s_if.COUNT), 32'(bcd(sv)));
      if (sv == 10) chk("up_09_to_10", 32'(s_if.COUNT), 32'h10);
    end
    chk("up_wrapped_00", 32'(s_if.COUNT), 32'h00);
    set_s(1, 0, 0, 8'h00, 1, 0);
    #1 chk("down_tc_at_00", 32'(s_if.TC), 32'h1);
    tick;
    chk("down_wrap_59", 32'(s_if.COUNT), 32'h59);
    chk("down_tc_at_59", 32'(s_if.TC), 32'h0);
    tick;
    chk("down_58", 32'(s_if.COUNT), 32'h58);
    set_s(1, 0, 1, 8'h45, 0, 1);
    tick;
    chk("ld_45", 32'(s_if.COUNT), 32'h45);
    chk("ld_45_err", 32'(s_if.LD_ERR), 32'h0);
    set_s(1, 0, 1, 8'h60, 0, 1);
    tick;
    chk("ld_60_count", 32'(s_if.COUNT), 32'h45);
    chk("ld_60_err", 32'(s_if.LD_ERR), 32'h1);
    set_s(1, 0, 0, 8'h60, 0, 1);
    tick;
    chk("ld_err_one_cycle", 32'(s_if.LD_ERR), 32'h0);
    set_s(1, 0, 1, 8'h3A, 0, 1);
    tick;
    chk("ld_3A_count", 32'(s_if.COUNT), 32'h45);
    chk("ld_3A_err", 32'(s_if.LD_ERR), 32'h1);
    set_s(1, 1, 1, 8'h22, 1, 1);
    #1 chk("sclr_tc", 32'(s_if.TC), 32'h0);
    tick;
    chk("sclr_priority", 32'(s_if.COUNT), 32'h00);
    chk("sclr_err", 32'(s_if.LD_ERR), 32'h0);
    set_s(1, 0, 1, 8'h30, 1, 1);
    tick;
    chk("ld_over_cnt", 32'(s_if.COUNT), 32'h30);
    set_s(1, 0, 1, 8'h59, 0, 1);
    tick;
    set_s(1, 0, 1, 8'hFF, 0, 1);
    tick;
    chk("ld_FF_err", 32'(s_if.LD_ERR), 32'h1);
    set_s(0, 0, 1, 8'h11, 1, 1);
    #1 chk("disabled_tc", 32'(s_if.TC), 32'h0);
    tick;
    chk("disabled_count", 32'(s_if.COUNT), 32'h59);
    chk("disabled_err", 32'(s_if.LD_ERR), 32'h0);
    set_h(1, 0, 1, 8'h12, 0, 1);
    tick;
    chk("hr_ld_12", 32'(h_if.COUNT), 32'h12);
    set_h(1, 0, 0, 8'h00, 1, 1);
    #1 chk("hr_up_tc", 32'(h_if.TC), 32'h1);
    tick;
    chk("hr_up_wrap", 32'(h_if.COUNT), 32'h01);
    set_h(1, 0, 0, 8'h00, 1, 0);
    #1 chk("hr_down_tc", 32'(h_if.TC), 32'h1);
    tick;
    chk("hr_down_wrap", 32'(h_if.COUNT), 32'h12);
    set_h(1, 0, 1, 8'h00, 0, 0);
    tick;
    chk("hr_ld_00_count", 32'(h_if.COUNT), 32'h12);
    chk("hr_ld_00_err", 32'(h_if.LD_ERR), 32'h1);
    set_s(1, 0, 1, 8'h37, 0, 1);
    tick;
    set_s(1, 0, 1, 8'hA0, 0, 1);
    tick;
    chk("pre_reset_count", 32'(s_if.COUNT), 32'h37);
    chk("pre_reset_err", 32'(s_if.LD_ERR), 32'h1);
    set_s(1, 0, 0, 8'h00, 1, 1);
    #2 Clr = 1'b0;
    #1;
    chk("async_reset_count", 32'(s_if.COUNT), 32'h00);
    chk("async_reset_err", 32'(s_if.LD_ERR), 32'h0);
    chk("async_reset_hr", 32'(h_if.COUNT), 32'h01);
    @(negedge Clk) Clr = 1'b1;
    #1 chk("resume_00", 32'(s_if.COUNT), 32'h00);
    tick;
    chk("resume_01", 32'(s_if.COUNT), 32'h01);
    tick;
    chk("resume_02", 32'(s_if.COUNT), 32'h02);
    set_s(1, 0, 1, 8'h59, 0, 1);
    m_if.Enable = 1; m_if.LD = 1; m_if.D_IN = 8'h59;
    tick;
    set_s(1, 0, 0, 8'h00, 1, 1);
    m_if.LD = 0;
    #1;
    chk("cascade_sec_tc", 32'(s_if.TC), 32'h1);
    chk("cascade_min_tc", 32'(m_if.TC), 32'h1);
    tick;
    chk("cascade_sec_00", 32'(s_if.COUNT), 32'h00);
    chk("cascade_min_00", 32'(m_if.COUNT), 32'h00);
    chk("cascade_min_tc_after", 32'(m_if.TC), 32'h0);
    m_if.Enable = 0;
    sv = 0; se = 0; hv = 1; he = 0;
    for (int i = 0; i < 400; i++) begin
      set_s(($urandom % 8) != 0, ($urandom % 16) == 0, ($urandom % 5) == 0,
            ($urandom % 2) ? 8'(bcd(int'($urandom_range(0, 59)))) : 8'($urandom), ($urandom % 4) != 0, 1'($urandom));
      set_h(($urandom % 8) != 0, ($urandom % 16) == 0, ($urandom % 5) == 0,
            ($urandom % 2) ? 8'(bcd(int'($urandom_range(0, 13)))) : 8'($urandom), ($urandom % 4) != 0, 1'($urandom));
      #1;
      chk("rnd_sec_tc", 32'(s_if.TC), 32'(s_if.Enable && s_if.Cnt && !s_if.Sclr && !s_if.LD && (s_if.Dir ? sv == 59 : sv == 0)));
      chk("rnd_hr_tc", 32'(h_if.TC), 32'(h_if.Enable && h_if.Cnt && !h_if.Sclr && !h_if.LD && (h_if.Dir ? hv == 12 : hv == 1)));
      se = nerr(0, 59, s_if.Enable, s_if.Sclr, s_if.LD, s_if.D_IN);
      sv = nxt(sv, 0, 59, s_if.Enable, s_if.Sclr, s_if.LD, s_if.D_IN, s_if.Cnt, s_if.Dir);
      he = nerr(1, 12, h_if.Enable, h_if.Sclr, h_if.LD, h_if.D_IN);
      hv = nxt(hv, 1, 12, h_if.Enable, h_if.Sclr, h_if.LD, h_if.D_IN, h_if.Cnt, h_if.Dir);
      tick;
      chk("rnd_sec_count", 32'(s_if.COUNT), 32'(bcd(sv)));
      chk("rnd_sec_err", 32'(s_if.LD_ERR), 32'(se));
      chk("rnd_hr_count", 32'(h_if.COUNT), 32'(bcd(hv)));
      chk("rnd_hr_err", 32'(h_if.LD_ERR), 32'(he));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
